// File: rtl/dfi_ddr3_responder_pkg.sv
// dfi_ddr3_responder_pkg: DFI command encodings and bank-table helpers shared by the responder.
package dfi_ddr3_responder_pkg;

    localparam int NUM_BANKS = 8;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_NOP = 3'b111
    } dfi_cmd_e;

    function automatic logic [NUM_BANKS-1:0] bank_bit(input logic [2:0] bank);
        return NUM_BANKS'(1) << bank;
    endfunction

endpackage

// File: rtl/dfi_addr_fifo.sv
// dfi_addr_fifo: small synchronous FIFO for pending burst addresses; caller guarantees legal push/pop.
module dfi_addr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, rp_q;

    assign empty_o = wp_q == rp_q;
    assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign data_o  = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else if (flush_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_q + (AW+1)'(push_i);
            rp_q <= rp_q + (AW+1)'(pop_i);
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) mem_q[wp_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/dfi_ddr3_responder.sv
// dfi_ddr3_responder: DFI command decoder, open-row table and BL8 RAM model standing in for
// a DDR3 PHY plus device; sticky flags record protocol violations.
module dfi_ddr3_responder
    import dfi_ddr3_responder_pkg::*;
#(
    parameter int DDR_ROW_BITS = 13,
    parameter int DDR_COL_BITS = 10,
    parameter int WIDTH        = 32,
    parameter int PHY_RD_DELAY = 3,
    parameter int MEM_ABITS    = 10,
    parameter int CMDQ_DEPTH   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    dfi_rst_ni,
    input  logic                    dfi_cke_i,
    input  logic                    dfi_cs_ni,
    input  logic                    dfi_ras_ni,
    input  logic                    dfi_cas_ni,
    input  logic                    dfi_we_ni,
    input  logic                    dfi_odt_i,
    input  logic [2:0]              dfi_bank_i,
    input  logic [DDR_ROW_BITS-1:0] dfi_addr_i,
    input  logic                    dfi_wstb_i,
    input  logic                    dfi_wren_i,
    input  logic [WIDTH/8-1:0]      dfi_mask_i,
    input  logic [WIDTH-1:0]        dfi_data_i,
    input  logic                    dfi_rden_i,
    output logic                    dfi_rvld_o,
    output logic                    dfi_last_o,
    output logic [WIDTH-1:0]        dfi_data_o,
    output logic                    err_o,
    output logic [2:0]              err_code_o
);
    localparam int QW = MEM_ABITS - 2;

    dfi_cmd_e                             cmd;
    logic                                 cmd_v, is_act, is_pre, is_rd, is_wr, a10, bank_open;
    logic [NUM_BANKS-1:0]                 open_q, open_d;
    logic [DDR_ROW_BITS-1:0]              row_q [NUM_BANKS];
    logic [DDR_ROW_BITS-1:0]              row_d [NUM_BANKS];
    logic [DDR_ROW_BITS+DDR_COL_BITS-1:0] wide;
    logic [QW-1:0]                        base, rd_head, wr_head;
    logic                                 rd_full, rd_empty, wr_full, wr_empty;
    logic                                 rd_req, wr_req, rd_push, wr_push;
    logic                                 rd_go, wr_go, rd_pop, wr_pop, q_err;
    logic [1:0]                           rbeat_q, rbeat_d, wbeat_q, wbeat_d;
    logic [2:0]                           err_q, err_d;
    logic [WIDTH-1:0]                     mem [2**MEM_ABITS];
    logic [WIDTH-1:0]                     ram_q;
    logic [PHY_RD_DELAY-1:0]              v_q, l_q;
    logic [WIDTH-1:0]                     d_q [PHY_RD_DELAY-1];
    logic                                 unused;

    assign cmd       = dfi_cmd_e'({dfi_ras_ni, dfi_cas_ni, dfi_we_ni});
    assign cmd_v     = dfi_cke_i & dfi_rst_ni & ~dfi_cs_ni;
    assign is_act    = cmd_v && cmd == CMD_ACT;
    assign is_pre    = cmd_v && cmd == CMD_PRE;
    assign is_rd     = cmd_v && cmd == CMD_RD;
    assign is_wr     = cmd_v && cmd == CMD_WR;
    assign a10       = dfi_addr_i[10];
    assign bank_open = open_q[dfi_bank_i];

    // Queues hold the burst-aligned word address; the low two bits are the beat counter.
    assign wide = {dfi_bank_i, row_q[dfi_bank_i], dfi_addr_i[DDR_COL_BITS-1:3]};
    assign base = wide[QW-1:0];

    assign rd_req  = is_rd & bank_open;
    assign wr_req  = is_wr & bank_open;
    assign rd_go   = dfi_rden_i & dfi_rst_ni & ~rd_empty;
    assign wr_go   = dfi_wren_i & dfi_rst_ni & ~wr_empty;
    assign rd_pop  = rd_go & (rbeat_q == 2'd3);
    assign wr_pop  = wr_go & (wbeat_q == 2'd3);
    assign rd_push = rd_req & (~rd_full | rd_pop);
    assign wr_push = wr_req & (~wr_full | wr_pop);
    assign q_err   = (rd_req & ~rd_push) | (wr_req & ~wr_push)
                   | (dfi_rden_i & dfi_rst_ni & rd_empty) | (dfi_wren_i & dfi_rst_ni & wr_empty);
    assign err_d   = err_q | {q_err, is_act & bank_open, (is_rd | is_wr) & ~bank_open};
    assign rbeat_d = !dfi_rst_ni ? 2'd0 : rbeat_q + 2'(rd_go);
    assign wbeat_d = !dfi_rst_ni ? 2'd0 : wbeat_q + 2'(wr_go);

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        if (!dfi_rst_ni) open_d = '0;
        else if (is_act) begin
            open_d[dfi_bank_i] = 1'b1;
            row_d[dfi_bank_i]  = dfi_addr_i;
        end else if (is_pre) open_d = a10 ? '0 : open_q & ~bank_bit(dfi_bank_i);
        else if ((is_rd | is_wr) && a10) open_d[dfi_bank_i] = 1'b0;
    end

    dfi_addr_fifo #(.W(QW), .DEPTH(CMDQ_DEPTH)) u_rd_q (
        .clock(clock), .reset(reset), .flush_i(~dfi_rst_ni), .push_i(rd_push), .pop_i(rd_pop),
        .data_i(base), .data_o(rd_head), .full_o(rd_full), .empty_o(rd_empty)
    );

    dfi_addr_fifo #(.W(QW), .DEPTH(CMDQ_DEPTH)) u_wr_q (
        .clock(clock), .reset(reset), .flush_i(~dfi_rst_ni), .push_i(wr_push), .pop_i(wr_pop),
        .data_i(base), .data_o(wr_head), .full_o(wr_full), .empty_o(wr_empty)
    );

    // RAM is not reset so contents survive a controller reset; reads see pre-write data.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WIDTH/8; i++)
            if (wr_go && !dfi_mask_i[i]) mem[{wr_head, wbeat_q}][8*i +: 8] <= dfi_data_i[8*i +: 8];
        if (rd_go) ram_q <= mem[{rd_head, rbeat_q}];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            open_q  <= '0;
            row_q   <= '{default: '0};
            rbeat_q <= '0;
            wbeat_q <= '0;
            err_q   <= '0;
            v_q     <= '0;
            l_q     <= '0;
            d_q     <= '{default: '0};
        end else begin
            open_q  <= open_d;
            row_q   <= row_d;
            rbeat_q <= rbeat_d;
            wbeat_q <= wbeat_d;
            err_q   <= err_d;
            v_q     <= {v_q[PHY_RD_DELAY-2:0], rd_go};
            l_q     <= {l_q[PHY_RD_DELAY-2:0], rd_pop};
            if (v_q[0]) d_q[0] <= ram_q;
            for (int i = 1; i < PHY_RD_DELAY-1; i++)
                if (v_q[i]) d_q[i] <= d_q[i-1];
        end
    end

    assign dfi_rvld_o = v_q[PHY_RD_DELAY-1];
    assign dfi_last_o = l_q[PHY_RD_DELAY-1];
    assign dfi_data_o = d_q[PHY_RD_DELAY-2];
    assign err_code_o = err_q;
    assign err_o      = |err_q;
    assign unused     = ^{dfi_odt_i, dfi_wstb_i, dfi_addr_i, wide};
endmodule
